lsu_bus_bridge: RTL and testbench

- Memory-stage responder for the pipeline's memory control signals (MemWriteM, load indication, address and store data from the ALU/forwarding path).
- Converts each load or store into a single transaction on a variable-latency req/ack data bus.
- Holds the pipeline through StallMem for the duration of the transaction.
- Returns sign- or zero-extended load data to the writeback path.

---
 rtl/lsu_bus_bridge.sv | 196 +++++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
//
// Memory-stage load/store responder. Each load or store seen in the memory
// stage becomes one transaction on a variable-latency req/ack data bus. The
// pipeline is held through StallMem while the transaction is outstanding.
// Load data comes back sign- or zero-extended for writeback.
//
// Handshake: bus_req rises on the cycle after a legal access is accepted and
// stays high, with bus_we/bus_addr/bus_wdata/bus_be stable, until the cycle in
// which bus_ack is sampled high (one-cycle completion, bus_rdata valid with it)
// or until the timeout budget runs out. bus_ack outside REQ is ignored.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   MemWriteM, MemReadM  store / load in memory stage (store wins if both)
//   funct3M              size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM           byte address
//   WriteDataM           right-aligned store data
//   StallMem             pipeline hold (combinational)
//   ReadDataM            extended load data, valid in DONE
//   MisalignM            one-cycle pulse for illegal/misaligned access
//   BusTimeoutM          one-cycle pulse (DONE) for an aborted access
//   bus_*                data bus request side
//   dbg_state            FSM state (0 IDLE, 1 REQ, 2 DONE)
// -----------------------------------------------------------------------------
module lsu_bus_bridge #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            StallMem,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MisalignM,
    output logic            BusTimeoutM,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic            r_timeout;
    logic            r_bus_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_be;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [XLEN-1:0] r_rdata;

    logic            w_access;
    logic            w_legal;
    logic            w_start;
    logic            w_misalign;
    logic [1:0]      w_lane;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_ext;

    assign w_access = MemWriteM | MemReadM;
    assign w_lane   = ALUResultM[1:0];

    // Legality, byte enables and store-lane replication from the live inputs.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (funct3M)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: w_legal = ~w_lane[0];
            3'b010:         w_legal = (w_lane == 2'b00);
            default:        w_legal = 1'b0;
        endcase
        case (funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {(XLEN/8){WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_lane;
                w_wdata = {(XLEN/16){WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
    end

    // Load lane extraction uses the lane and size latched at acceptance.
    assign w_byte = 8'(bus_rdata >> {r_lane, 3'b000});
    assign w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        w_load_ext = bus_rdata;
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ext = bus_rdata;
        endcase
    end

    // Gating with reset keeps the combinational outputs quiet while reset is low.
    assign w_start    = reset & (r_state == S_IDLE) & w_access & w_legal;
    assign w_misalign = reset & (r_state == S_IDLE) & w_access & ~w_legal;

    assign StallMem    = w_start | (reset & (r_state == S_REQ));
    assign MisalignM   = w_misalign;
    assign ReadDataM   = w_misalign ? '0 : r_rdata;
    assign BusTimeoutM = r_timeout;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_we;
    assign bus_addr    = r_addr;
    assign bus_wdata   = r_wdata;
    assign bus_be      = r_be;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_bus_req <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_funct3  <= '0;
            r_lane    <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timeout <= 1'b0;
                    r_cnt     <= '0;
                    if (w_start) begin
                        r_bus_req <= 1'b1;
                        r_we      <= MemWriteM;
                        r_addr    <= {ALUResultM[XLEN-1:2], 2'b00};
                        r_wdata   <= w_wdata;
                        r_be      <= w_be;
                        r_funct3  <= funct3M;
                        r_lane    <= w_lane;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_rdata   <= r_we ? '0 : w_load_ext;
                        r_state   <= S_DONE;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        // Abort: report through BusTimeoutM and return zero data.
                        r_bus_req <= 1'b0;
                        r_timeout <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_timeout <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
module tb_lsu_bus_bridge;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk;
  logic            reset;
  logic            MemWriteM, MemReadM;
  logic [2:0]      funct3M;
  logic [XLEN-1:0] ALUResultM, WriteDataM;
  logic            StallMem;
  logic [XLEN-1:0] ReadDataM;
  logic            MisalignM, BusTimeoutM;
  logic            bus_req, bus_we;
  logic [XLEN-1:0] bus_addr, bus_wdata;
  logic [3:0]      bus_be;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;
  logic [1:0]      dbg_state;

  lsu_bus_bridge #(.XLEN(XLEN), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallMem(StallMem), .ReadDataM(ReadDataM), .MisalignM(MisalignM),
    .BusTimeoutM(BusTimeoutM), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          we;
    bit          rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit we, input bit rd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int delay, input bit mis,
                              input logic [3:0] be, input logic [31:0] e_wdata,
                              input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.rd = rd; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.delay = delay; v.mis = mis;
    v.e_addr = {addr[31:2], 2'b00};
    v.e_be = be; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    MemWriteM = 1'b0; MemReadM = 1'b0; funct3M = 3'b000;
    ALUResultM = '0; WriteDataM = '0;
  endtask

  task automatic drive_access(input bit we, input bit rd, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM = we; MemReadM = rd; funct3M = f3; ALUResultM = addr; WriteDataM = wdata;
  endtask

  task automatic run_vec(input vec_t v);
    int          stall_cnt;
    int          req_cnt;
    bit          done;
    logic [31:0] exp_r;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    drive_access(v.we, v.rd, v.f3, v.addr, v.wdata);
    #1;
    if (v.mis) begin
      check("misalign_pulse", MisalignM, 1);
      check("misalign_stall", StallMem, 0);
      check("misalign_rdata", ReadDataM, 0);
      check("misalign_req", bus_req, 0);
      @(posedge clk); #1;
      idle_inputs();
      #1;
      check("misalign_clear", MisalignM, 0);
      check("misalign_noreq", bus_req, 0);
      check("misalign_state", dbg_state, 0);
      return;
    end
    check("start_stall", StallMem, 1);
    check("start_misalign", MisalignM, 0);
    exp_q.push_back(v.e_rdata);
    stall_cnt = 1;
    req_cnt   = 0;
    done      = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        req_cnt++;
        if (StallMem) stall_cnt++;
        check("bus_addr", bus_addr, v.e_addr);
        if (i == 0) begin
          check("bus_be", bus_be, v.e_be);
          check("bus_wdata", bus_wdata, v.e_wdata);
          check("bus_we", bus_we, v.we);
        end
        bus_ack   = (i == v.delay);
        bus_rdata = (i == v.delay) ? v.rdata : $urandom;
      end else begin
        done = 1'b1;
      end
    end
    bus_ack = 1'b0;
    check("req_bound", done, 1);
    #1;
    check("done_state", dbg_state, 2);
    check("done_stall", StallMem, 0);
    check("done_timeout", BusTimeoutM, 0);
    check("req_cycles", req_cnt, v.delay + 1);
    check("stall_cycles", stall_cnt, v.delay + 2);
    exp_r = exp_q.pop_front();
    check("read_data", ReadDataM, exp_r);
    idle_inputs();
    @(posedge clk); #1;
    check("back_idle", dbg_state, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, bus_req, 0);
    check({tag, "_stall"}, StallMem, 0);
    check({tag, "_we"}, bus_we, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_be"}, bus_be, 0);
    check({tag, "_rdata"}, ReadDataM, 0);
    check({tag, "_mis"}, MisalignM, 0);
    check({tag, "_tmo"}, BusTimeoutM, 0);
  endtask

  initial begin
    int          req_cnt;
    bit          done;
    logic [1:0]  lane;
    logic [31:0] rd_val;
    logic [31:0] a;

    reset = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    idle_inputs();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // we rd f3 addr wdata rdata delay mis be e_wdata e_rdata
    vecs.push_back(mk(0,1,3'b010,32'h100,0,32'hDEADBEEF,3,0,4'b1111,0,32'hDEADBEEF));
    vecs.push_back(mk(1,0,3'b000,32'h203,32'h000000A5,0,0,0,4'b1000,32'hA5A5A5A5,0));
    vecs.push_back(mk(0,1,3'b000,32'h2,0,32'h12F03456,1,0,4'b0100,0,32'hFFFFFFF0));
    vecs.push_back(mk(0,1,3'b100,32'h2,0,32'h12F03456,0,0,4'b0100,0,32'h000000F0));
    vecs.push_back(mk(0,1,3'b101,32'h2,0,32'h12F03456,2,0,4'b1100,0,32'h000012F0));
    vecs.push_back(mk(0,1,3'b001,32'h6,0,32'h80017FFF,2,0,4'b1100,0,32'hFFFF8001));
    vecs.push_back(mk(0,1,3'b000,32'h11,0,32'h00008000,0,0,4'b0010,0,32'hFFFFFF80));
    vecs.push_back(mk(1,0,3'b001,32'h22,32'hCAFEBEEF,0,1,0,4'b1100,32'hBEEFBEEF,0));
    vecs.push_back(mk(1,0,3'b010,32'h40,32'h12345678,0,5,0,4'b1111,32'h12345678,0));
    vecs.push_back(mk(0,1,3'b010,32'h102,0,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,3'b001,32'h101,32'h1234,0,0,1,0,0,0));
    vecs.push_back(mk(0,1,3'b011,32'h100,0,0,0,1,0,0,0));
    vecs.push_back(mk(1,0,3'b110,32'h0,0,0,0,1,0,0,0));
    vecs.push_back(mk(0,1,3'b001,32'h3,0,0,0,1,0,0,0));
    vecs.push_back(mk(0,1,3'b100,32'h3,0,32'h9A000000,1,0,4'b1000,0,32'h0000009A));

    foreach (vecs[k]) run_vec(vecs[k]);

    // random byte-unsigned and word loads with random ack latency
    for (int k = 0; k < 6; k++) begin
      lane   = 2'($urandom_range(0, 3));
      rd_val = $urandom;
      a      = {22'd0, 8'($urandom_range(0, 255)), lane};
      if (k % 2 == 0)
        run_vec(mk(0,1,3'b100,a,0,rd_val,$urandom_range(0,4),0,
                   4'(1 << lane),0,(rd_val >> (8*lane)) & 32'hFF));
      else
        run_vec(mk(0,1,3'b010,{a[31:2],2'b00},0,rd_val,$urandom_range(0,4),0,
                   4'b1111,0,rd_val));
    end

    // reset asserted while a load is in REQ
    @(posedge clk); #1;
    drive_access(0, 1, 3'b010, 32'h44, 0);
    @(posedge clk); #1;
    check("rst_seq_req", bus_req, 1);
    @(posedge clk); #3;
    reset   = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h55555555;
    #1;
    check_all_zero("midrst");
    check("midrst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1;
    idle_inputs();
    bus_ack = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    check("postrst_state", dbg_state, 0);
    check("postrst_req", bus_req, 0);

    run_vec(mk(0,1,3'b010,32'h44,0,32'hC0FFEE11,2,0,4'b1111,0,32'hC0FFEE11));
    run_vec(mk(1,1,3'b010,32'h300,32'h11223344,32'hFFFFFFFF,1,0,4'b1111,32'h11223344,0));
    run_vec(mk(0,1,3'b000,32'h1,0,32'h00007F00,0,0,4'b0010,0,32'h0000007F));

    // load with no ack: abort after TO cycles in REQ
    @(posedge clk); #1;
    drive_access(0, 1, 3'b010, 32'h80, 0);
    #1;
    check("tmo_start_stall", StallMem, 1);
    req_cnt = 0;
    done    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        req_cnt++;
        bus_rdata = $urandom;
      end else begin
        done = 1'b1;
      end
    end
    check("tmo_bound", done, 1);
    #1;
    check("tmo_req_cycles", req_cnt, TO);
    check("tmo_flag", BusTimeoutM, 1);
    check("tmo_rdata", ReadDataM, 0);
    check("tmo_stall", StallMem, 0);
    check("tmo_state", dbg_state, 2);
    idle_inputs();
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    check("tmo_flag_clear", BusTimeoutM, 0);
    check("late_ack_req", bus_req, 0);
    check("late_ack_state", dbg_state, 0);
    check("late_ack_rdata", ReadDataM, 0);

    run_vec(mk(0,1,3'b101,32'h10,0,32'hABCD8765,0,0,4'b0011,0,32'h00008765));

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
